// File: rtl/fetch_stage.sv
// RV32I fetch stage: up to 2 requests in flight, 2-entry skid buffer; accept N -> rsp N+1 -> IF/ID N+2.
// Issue is credit-limited (in flight + buffered < 2), so a decode stall never drops a returned word.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4
);

  localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;
  localparam logic [1:0]  CREDITS       = 2'(MAX_OUTST);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;
  logic [1:0]  sup_q;

  logic [31:0] tag_q [2];
  logic        tag_wr_q, tag_rd_q;

  logic [31:0] sb_pc_q  [2];
  logic [31:0] sb_ins_q [2];
  logic        sb_wr_q, sb_rd_q;
  logic [1:0]  sb_cnt_q, sb_cnt_d;

  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic [31:0] ifid_p4_q, ifid_p4_d;

  logic        req_vld, accept;
  logic        rsp_fire, rsp_drop, rsp_live;
  logic        sb_push, sb_pop;
  logic [31:0] rsp_pc, redirect_tgt;

  always_comb begin
    redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    req_vld      = !rst && !redirect_valid && ((outst_q + sb_cnt_q) < CREDITS);
    accept       = req_vld && imem_req_ready;
    // A response with nothing outstanding is illegal and ignored entirely.
    rsp_fire     = imem_rsp_valid && (outst_q != 2'd0);
    rsp_drop     = rsp_fire && (drop_q != 2'd0);
    rsp_live     = rsp_fire && (drop_q == 2'd0);
    rsp_pc       = tag_q[tag_rd_q];
    sb_pop       = !stall_i && (sb_cnt_q != 2'd0);
    sb_push      = rsp_live && (stall_i || (sb_cnt_q != 2'd0));

    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    outst_d    = outst_q + {1'b0, accept} - {1'b0, rsp_fire};
    drop_d     = drop_q - {1'b0, rsp_drop};
    sb_cnt_d   = sb_cnt_q + {1'b0, sb_push} - {1'b0, sb_pop};

    ifid_vld_d = ifid_vld_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_ins_d = ifid_ins_q;
    ifid_p4_d  = ifid_p4_q;

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the wrong path.
      fetch_pc_d = redirect_tgt;
      outst_d    = outst_q - {1'b0, rsp_fire};
      drop_d     = outst_q - {1'b0, rsp_fire};
      sb_cnt_d   = 2'd0;
      ifid_vld_d = 1'b0;
      ifid_ins_d = NOP_INSTR_HEX;
    end else if (!stall_i) begin
      if (sb_cnt_q != 2'd0) begin
        ifid_vld_d = 1'b1;
        ifid_pc_d  = sb_pc_q[sb_rd_q];
        ifid_ins_d = sb_ins_q[sb_rd_q];
        ifid_p4_d  = sb_pc_q[sb_rd_q] + 32'd4;
      end else if (rsp_live) begin
        ifid_vld_d = 1'b1;
        ifid_pc_d  = rsp_pc;
        ifid_ins_d = imem_rsp_data;
        ifid_p4_d  = rsp_pc + 32'd4;
      end else begin
        ifid_vld_d = 1'b0;
        ifid_ins_d = NOP_INSTR_HEX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= 2'd0;
      drop_q     <= 2'd0;
      sup_q      <= 2'd2;
      tag_wr_q   <= 1'b0;
      tag_rd_q   <= 1'b0;
      sb_wr_q    <= 1'b0;
      sb_rd_q    <= 1'b0;
      sb_cnt_q   <= 2'd0;
      ifid_vld_q <= 1'b0;
      ifid_pc_q  <= 32'd0;
      ifid_ins_q <= NOP_INSTR_HEX;
      ifid_p4_q  <= 32'd4;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      sb_cnt_q   <= sb_cnt_d;
      ifid_vld_q <= ifid_vld_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_ins_q <= ifid_ins_d;
      ifid_p4_q  <= ifid_p4_d;
      if (sup_q != 2'd0) sup_q <= sup_q - 2'd1;

      if (redirect_valid) begin
        tag_wr_q <= 1'b0;
        tag_rd_q <= 1'b0;
        sb_wr_q  <= 1'b0;
        sb_rd_q  <= 1'b0;
      end else begin
        if (accept) begin
          tag_q[tag_wr_q] <= fetch_pc_q;
          tag_wr_q        <= ~tag_wr_q;
        end
        if (rsp_live) tag_rd_q <= ~tag_rd_q;
        if (sb_push) begin
          sb_pc_q[sb_wr_q]  <= rsp_pc;
          sb_ins_q[sb_wr_q] <= imem_rsp_data;
          sb_wr_q           <= ~sb_wr_q;
        end
        if (sb_pop) sb_rd_q <= ~sb_rd_q;
      end
    end
  end

  // Responses still in flight across a reset may land before the memory side has flushed.
  rsp_without_req: assert property (@(posedge clk) disable iff (rst || (sup_q != 2'd0))
    !(imem_rsp_valid && (outst_q == 2'd0)));

  assign imem_req_valid = req_vld;
  assign imem_req_addr  = fetch_pc_q;
  assign if_id_valid    = ifid_vld_q;
  assign if_id_pc       = ifid_pc_q;
  assign if_id_instr    = ifid_ins_q;
  assign if_id_pc_plus4 = ifid_p4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with budgeted grants and an IF/ID scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          budget = 0;
  int          errors = 0;
  int          checks = 0;
  logic        load_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = pc | 32'hA000_0000;
    e.p4  = pc + 32'd4;
    exp_q.push_back(e);
  endtask

  // One clock: grant while budget lasts, return the oldest word once its latency has elapsed.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    imem_req_ready = !rst && (budget > 0);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if (!rst && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr_q[0] | 32'hA000_0000;
    end
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    if (rst) begin
      mem_addr_q.delete();
      mem_due_q.delete();
    end else begin
      if (imem_rsp_valid) begin
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end
      if (acc) begin
        mem_addr_q.push_back(a);
        mem_due_q.push_back(cyc + lat);
        budget--;
      end
    end
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((exp_q.size() > 0 || mem_due_q.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_pc(input logic [31:0] pc, input int maxc);
    int n = 0;
    while (!(if_id_valid && if_id_pc == pc) && n < maxc) begin
      step();
      n++;
    end
    chk("wait_pc", if_id_pc, pc);
  endtask

  always @(posedge clk) load_q <= !rst && !stall_i && !redirect_valid;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (load_q) begin
      if (if_id_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h expected none", if_id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("ifid_pc", if_id_pc, e.pc);
          chk("ifid_instr", if_id_instr, e.ins);
          chk("ifid_pc_plus4", if_id_pc_plus4, e.p4);
        end
      end else begin
        chk("idle_nop", if_id_instr, NOP);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_pc_plus4", if_id_pc_plus4, 32'd4);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    // Back-to-back stream, then a 4-cycle decode stall with 0x8 in IF/ID.
    budget = 6;
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    wait_pc(32'h8, 20);
    stall_i = 1'b1;
    step(); step();
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_hold_pc", if_id_pc, 32'h8);
    step(); step();
    chk("stall_hold_pc2", if_id_pc, 32'h8);
    chk("stall_hold_valid", {31'd0, if_id_valid}, 32'd1);
    stall_i = 1'b0;
    step();
    chk("release_pc0", if_id_pc, 32'hC);
    step();
    chk("release_pc1", if_id_pc, 32'h10);
    drain(30);

    // Memory not ready: request address held, IF/ID drains to NOP.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_addr", imem_req_addr, 32'h18);
    end
    chk("held_valid", {31'd0, if_id_valid}, 32'd0);
    chk("held_instr", if_id_instr, NOP);
    budget = 1;
    push_exp(32'h18);
    step();
    chk("resume_addr", imem_req_addr, 32'h1C);
    drain(20);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    budget = 2;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_instr", if_id_instr, NOP);
    chk("redir_addr", imem_req_addr, 32'h100);
    budget = 2;
    push_exp(32'h100);
    push_exp(32'h104);
    drain(40);

    // Redirect beats a stall; target low bits are cleared.
    lat = 1;
    budget = 1;
    push_exp(32'h108);
    wait_pc(32'h108, 20);
    stall_i = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h202;
    #1;
    chk("stall_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    stall_i = 1'b0; redirect_valid = 1'b0;
    chk("stall_redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("stall_redir_instr", if_id_instr, NOP);
    chk("stall_redir_addr", imem_req_addr, 32'h200);
    budget = 1;
    push_exp(32'h200);
    drain(20);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    budget = 2;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    step();
    chk("wrap_addr", imem_req_addr, 32'h0);
    drain(20);

    // Reset with requests in flight.
    lat = 3;
    budget = 2;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("midrst_pc_plus4", if_id_pc_plus4, 32'd4);
    chk("midrst_instr", if_id_instr, NOP);
    rst = 1'b0;
    #1;
    chk("midrst_addr", imem_req_addr, 32'h0);
    budget = 0;
    for (int i = 0; i < 5; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
